// File: rtl/huffman_pkg.sv
// Shared constants and FSM state type for the Huffman frequency/min-finder stage.
package huffman_pkg;

    localparam int SYM_N     = 10;
    localparam int NODE_N    = 19;
    localparam int IDX_W     = 5;
    localparam int ROOT_BASE = 10;
    localparam int MERGE_N   = 9;

    typedef enum logic [1:0] {
        ST_COUNT,
        ST_MERGE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/huffman_min2.sv
// Combinational finder for the two lowest-weight active nodes, lowest index wins ties.
module huffman_min2
    import huffman_pkg::*;
#(
    parameter int W_W = 20
) (
    input  logic [NODE_N-1:0]          i_active,
    input  logic [NODE_N-1:0][W_W-1:0] i_weight,
    output logic [IDX_W-1:0]           o_min1,
    output logic [IDX_W-1:0]           o_min2
);

    logic           w_found1;
    logic           w_found2;
    logic [W_W-1:0] w_best1;
    logic [W_W-1:0] w_best2;

    // Strict less-than while scanning upward keeps the lowest index on a tie.
    always_comb begin
        w_found1 = 1'b0;
        w_found2 = 1'b0;
        w_best1  = '0;
        w_best2  = '0;
        o_min1   = '0;
        o_min2   = '0;
        for (int i = 0; i < NODE_N; i++) begin
            if (i_active[i] && (!w_found1 || (i_weight[i] < w_best1))) begin
                w_found1 = 1'b1;
                w_best1  = i_weight[i];
                o_min1   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NODE_N; i++) begin
            if (i_active[i] && (IDX_W'(i) != o_min1) &&
                (!w_found2 || (i_weight[i] < w_best2))) begin
                w_found2 = 1'b1;
                w_best2  = i_weight[i];
                o_min2   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/huffman_freq_min.sv
// Counts symbol frequencies, then presents the two smallest active nodes each cycle of the tree merge.
module huffman_freq_min
    import huffman_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int W_W   = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sym_valid,
    input  logic [3:0]       sym,
    input  logic             sym_last,
    output logic             sym_ready,
    input  logic [IDX_W-1:0] new_root_index,
    output logic             data_count_finish,
    output logic [IDX_W-1:0] min1,
    output logic [IDX_W-1:0] min2,
    output logic             merge_done,
    output logic             sym_err
);

    localparam logic [W_W-1:0] CNT_MAX = W_W'((64'd1 << CNT_W) - 64'd1);

    state_t                   r_state;
    logic [W_W-1:0]           r_weight [NODE_N];
    logic [NODE_N-1:0]        r_active;
    logic [3:0]               r_mergeCnt;
    logic                     r_symReady;
    logic                     r_dataCountFinish;
    logic                     r_mergeDone;
    logic                     r_symErr;
    logic [IDX_W-1:0]         r_min1;
    logic [IDX_W-1:0]         r_min2;

    logic [NODE_N-1:0][W_W-1:0] w_weightBus;
    logic [IDX_W-1:0]           w_min1;
    logic [IDX_W-1:0]           w_min2;
    logic [W_W-1:0]             w_sum;
    logic                       w_accept;
    logic                       w_symLegal;
    logic                       w_rootOk;

    always_comb begin
        for (int i = 0; i < NODE_N; i++) begin
            w_weightBus[i] = r_weight[i];
        end
    end

    huffman_min2 #(.W_W(W_W)) u_min2 (
        .i_active (r_active),
        .i_weight (w_weightBus),
        .o_min1   (w_min1),
        .o_min2   (w_min2)
    );

    assign w_accept   = sym_valid & r_symReady & (r_state == ST_COUNT);
    assign w_symLegal = (sym < 4'(SYM_N));
    assign w_rootOk   = (new_root_index >= IDX_W'(ROOT_BASE)) &&
                        (new_root_index <  IDX_W'(NODE_N));
    assign w_sum      = w_weightBus[w_min1] + w_weightBus[w_min2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= ST_COUNT;
            for (int i = 0; i < NODE_N; i++) begin
                r_weight[i] <= '0;
            end
            r_active          <= NODE_N'((1 << SYM_N) - 1);
            r_mergeCnt        <= '0;
            r_symReady        <= 1'b1;
            r_dataCountFinish <= 1'b0;
            r_mergeDone       <= 1'b0;
            r_symErr          <= 1'b0;
            r_min1            <= IDX_W'(0);
            r_min2            <= IDX_W'(1);
        end else begin
            case (r_state)
                ST_COUNT: begin
                    if (w_accept) begin
                        if (w_symLegal) begin
                            if (r_weight[sym] != CNT_MAX) begin
                                r_weight[sym] <= r_weight[sym] + W_W'(1);
                            end
                        end else begin
                            r_symErr <= 1'b1;
                        end
                        if (sym_last) begin
                            r_state           <= ST_MERGE;
                            r_symReady        <= 1'b0;
                            r_dataCountFinish <= 1'b1;
                        end
                    end
                end
                ST_MERGE: begin
                    // The new root slot is never one of the two minima: it is inactive until this edge.
                    r_active[w_min1] <= 1'b0;
                    r_active[w_min2] <= 1'b0;
                    if (w_rootOk) begin
                        r_weight[new_root_index] <= w_sum;
                        r_active[new_root_index] <= 1'b1;
                    end
                    r_min1     <= w_min1;
                    r_min2     <= w_min2;
                    r_mergeCnt <= r_mergeCnt + 4'd1;
                    if (r_mergeCnt == 4'(MERGE_N - 1)) begin
                        r_state     <= ST_DONE;
                        r_mergeDone <= 1'b1;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    r_state <= ST_COUNT;
                end
            endcase
        end
    end

    assign sym_ready         = r_symReady;
    assign data_count_finish = r_dataCountFinish;
    assign merge_done        = r_mergeDone;
    assign sym_err           = r_symErr;
    assign min1              = (r_state == ST_MERGE) ? w_min1 : r_min1;
    assign min2              = (r_state == ST_MERGE) ? w_min2 : r_min2;

endmodule

// File: tb/tb_huffman_freq_min.sv
// Directed self-checking bench for huffman_freq_min, built with CNT_W=4 so saturation is reachable.
module tb_huffman_freq_min;

    logic       clk = 1'b0;
    logic       rst;
    logic       sym_valid;
    logic [3:0] sym;
    logic       sym_last;
    logic       sym_ready;
    logic [4:0] new_root_index;
    logic       data_count_finish;
    logic [4:0] min1;
    logic [4:0] min2;
    logic       merge_done;
    logic       sym_err;

    int checks = 0;
    int errors = 0;

    // Hand-derived merge order for symbol k sent k+1 times.
    int expMin1 [9] = '{0, 2, 3, 5, 6, 8, 9, 14, 16};
    int expMin2 [9] = '{1, 10, 4, 11, 7, 12, 13, 15, 17};

    huffman_freq_min #(.CNT_W(4), .W_W(20)) dut (
        .clk               (clk),
        .rst               (rst),
        .sym_valid         (sym_valid),
        .sym               (sym),
        .sym_last          (sym_last),
        .sym_ready         (sym_ready),
        .new_root_index    (new_root_index),
        .data_count_finish (data_count_finish),
        .min1              (min1),
        .min2              (min2),
        .merge_done        (merge_done),
        .sym_err           (sym_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst       = 1'b1;
        sym_valid = 1'b0;
        sym_last  = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] s, input logic last);
        sym_valid = 1'b1;
        sym       = s;
        sym_last  = last;
        tick();
        sym_valid = 1'b0;
        sym_last  = 1'b0;
    endtask

    task automatic sendCleanStream(input bit withBad);
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j <= k; j++) begin
                applyStimulus(4'(k), (k == 9) && (j == k));
            end
            if (withBad && k == 4) begin
                applyStimulus(4'd12, 1'b0);
                checkOutput("symErrSet", 32'(sym_err), 32'd1);
            end
        end
    endtask

    task automatic runMerges(input int n, input bit checkPairs);
        for (int m = 0; m < n; m++) begin
            new_root_index = 5'(10 + m);
            if (checkPairs) begin
                checkOutput($sformatf("min1_m%0d", m), 32'(min1), 32'(expMin1[m]));
                checkOutput($sformatf("min2_m%0d", m), 32'(min2), 32'(expMin2[m]));
            end
            checkOutput($sformatf("mergeDoneLow_m%0d", m), 32'(merge_done), 32'd0);
            tick();
        end
    endtask

    task automatic checkScenarioOne(input string tag);
        checkOutput({tag, "_dcf"}, 32'(data_count_finish), 32'd1);
        checkOutput({tag, "_readyLow"}, 32'(sym_ready), 32'd0);
        runMerges(9, 1'b1);
        checkOutput({tag, "_mergeDone"}, 32'(merge_done), 32'd1);
        checkOutput({tag, "_dcfHeld"}, 32'(data_count_finish), 32'd1);
        checkOutput({tag, "_root"}, 32'(dut.r_weight[18]), 32'd55);
        checkOutput({tag, "_min1Hold"}, 32'(min1), 32'd16);
        checkOutput({tag, "_min2Hold"}, 32'(min2), 32'd17);
    endtask

    initial begin
        int cyc;
        rst            = 1'b0;
        sym_valid      = 1'b0;
        sym            = 4'd0;
        sym_last       = 1'b0;
        new_root_index = 5'd10;

        // Reset with a valid last beat present: beat must be ignored.
        rst       = 1'b1;
        sym_valid = 1'b1;
        sym       = 4'd3;
        sym_last  = 1'b1;
        tick();
        tick();
        rst       = 1'b0;
        sym_valid = 1'b0;
        sym_last  = 1'b0;
        checkOutput("rstReady", 32'(sym_ready), 32'd1);
        checkOutput("rstDcf", 32'(data_count_finish), 32'd0);
        checkOutput("rstMergeDone", 32'(merge_done), 32'd0);
        checkOutput("rstSymErr", 32'(sym_err), 32'd0);
        checkOutput("rstMin1", 32'(min1), 32'd0);
        checkOutput("rstMin2", 32'(min2), 32'd1);
        checkOutput("rstW3", 32'(dut.r_weight[3]), 32'd0);

        $display("[TB] scenario: frequencies 1..10");
        sendCleanStream(1'b0);
        checkScenarioOne("s1");

        $display("[TB] scenario: symbol 5 only");
        doReset();
        for (int j = 0; j < 4; j++) applyStimulus(4'd5, j == 3);
        checkOutput("s2_min1", 32'(min1), 32'd0);
        checkOutput("s2_min2", 32'(min2), 32'd1);
        runMerges(9, 1'b0);
        checkOutput("s2_mergeDone", 32'(merge_done), 32'd1);
        checkOutput("s2_root", 32'(dut.r_weight[18]), 32'd4);
        checkOutput("s2_min1Hold", 32'(min1), 32'd17);
        checkOutput("s2_min2Hold", 32'(min2), 32'd5);

        $display("[TB] scenario: saturation");
        doReset();
        for (int j = 0; j < 20; j++) applyStimulus(4'd3, j == 19);
        checkOutput("s3_w3Sat", 32'(dut.r_weight[3]), 32'd15);
        checkOutput("s3_min1", 32'(min1), 32'd0);
        checkOutput("s3_min2", 32'(min2), 32'd1);

        $display("[TB] scenario: illegal symbol in stream");
        doReset();
        sendCleanStream(1'b1);
        checkScenarioOne("s4");
        checkOutput("s4_symErrSticky", 32'(sym_err), 32'd1);

        $display("[TB] scenario: reset mid-merge");
        doReset();
        sendCleanStream(1'b0);
        runMerges(3, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("s5_ready", 32'(sym_ready), 32'd1);
        checkOutput("s5_dcf", 32'(data_count_finish), 32'd0);
        checkOutput("s5_mergeDone", 32'(merge_done), 32'd0);
        for (int i = 0; i < 19; i++) begin
            checkOutput($sformatf("s5_w%0d", i), 32'(dut.r_weight[i]), 32'd0);
        end
        sendCleanStream(1'b0);
        checkScenarioOne("s5b");

        $display("[TB] scenario: single beat");
        doReset();
        applyStimulus(4'd7, 1'b1);
        checkOutput("s6_dcf", 32'(data_count_finish), 32'd1);
        cyc = 0;
        while (!merge_done && cyc < 20) begin
            new_root_index = (cyc < 9) ? 5'(10 + cyc) : 5'd18;
            tick();
            cyc++;
        end
        checkOutput("s6_latency", 32'(cyc), 32'd9);
        checkOutput("s6_root", 32'(dut.r_weight[18]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
